// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encoding for instruction_loader.
// LOADER_CHECKSUM_EN adds the CHECK state.
package loader_pkg;

    localparam int BYTES_PER_INSTR = 4;
    localparam int HEADER_BYTES    = 2;
    localparam int INSTR_WIDTH     = 28;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHECK  = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_e;

    function automatic logic acceptsBytes(input loader_state_e s);
        case (s)
            LEN_HI, LEN_LO, DATA: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:                return 1'b1;
`endif
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream in, instruction-memory writes and status out.
interface instruction_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) ();

    logic                    iStart;
    logic [7:0]              iByte;
    logic                    iByteValid;
    logic                    oByteReady;
    logic                    oWriteEnable;
    logic [ADDR_WIDTH-1:0]   oWriteAddress;
    logic [INSTR_WIDTH-1:0]  oInstruction;
    logic                    oCpuReset;
    logic                    oDone;
    logic                    oError;

    modport master (
        output iStart, iByte, iByteValid,
        input  oByteReady, oWriteEnable, oWriteAddress, oInstruction,
        input  oCpuReset, oDone, oError
    );

    modport slave (
        input  iStart, iByte, iByteValid,
        output oByteReady, oWriteEnable, oWriteAddress, oInstruction,
        output oCpuReset, oDone, oError
    );

endinterface

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs four big-endian bytes into one 28-bit instruction word.
module instr_packer
    import loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   byteAccept,
    input  logic [7:0]             byteIn,
    output logic [1:0]             byteCount,
    output logic                   wordValid,
    output logic [INSTR_WIDTH-1:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

    // 20 bits is exactly byte0[3:0], byte1, byte2 once three bytes are in.
    logic [19:0] shiftReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg  <= '0;
            byteCount <= '0;
            wordValid <= 1'b0;
            word      <= '0;
        end else if (clear) begin
            shiftReg  <= '0;
            byteCount <= '0;
            wordValid <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            if (byteAccept) begin
                shiftReg  <= {shiftReg[11:0], byteIn};
                byteCount <= byteCount + 2'd1;
                // Word is latched apart from shiftReg so it stays stable while byte0 of the next word arrives.
                if (byteCount == LAST_BYTE) begin
                    wordValid <= 1'b1;
                    word      <= {shiftReg, byteIn};
                end
            end
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads a length-prefixed byte program into instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_INSTR  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_loader_if.slave bus
);

    localparam logic [16:0] MAX_LEN   = 17'(MAX_INSTR);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

    loader_state_e           state;
    loader_state_e           finishState;
    logic [7:0]              lenHi;
    logic [15:0]             lenValue;
    logic [15:0]             wordsLeft;
    logic [ADDR_WIDTH-1:0]   addrCnt;
    logic                    byteAccept;
    logic                    startLoad;
    logic                    lenTooLong;
    logic                    badNibble;
    logic                    lastByteOfLoad;
    logic                    packerAccept;
    logic                    wordValid;
    logic [1:0]              byteCount;
    logic [INSTR_WIDTH-1:0]  word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              xorAcc;
    assign finishState = CHECK;
`else
    assign finishState = DONE;
`endif

    assign byteAccept     = bus.iByteValid && bus.oByteReady;
    assign startLoad      = bus.iStart && (state inside {IDLE, DONE, ERROR});
    assign lenValue       = {lenHi, bus.iByte};
    assign lenTooLong     = {1'b0, lenValue} > MAX_LEN;
    assign badNibble      = (byteCount == 2'd0) && (bus.iByte[7:4] != 4'd0);
    assign lastByteOfLoad = (byteCount == LAST_BYTE) && (wordsLeft == 16'd1);
    assign packerAccept   = byteAccept && (state == DATA) && !badNibble;

    assign bus.oByteReady    = acceptsBytes(state);
    assign bus.oWriteEnable  = wordValid;
    assign bus.oWriteAddress = addrCnt;
    assign bus.oInstruction  = word;

    instr_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (startLoad),
        .byteAccept (packerAccept),
        .byteIn     (bus.iByte),
        .byteCount  (byteCount),
        .wordValid  (wordValid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lenHi         <= '0;
            wordsLeft     <= '0;
            addrCnt       <= '0;
            bus.oDone     <= 1'b0;
            bus.oError    <= 1'b0;
            bus.oCpuReset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xorAcc        <= '0;
`endif
        end else begin
            // Status rises the cycle after DONE/ERROR is entered, so the CPU leaves
            // reset only after the final write strobe; a restart drops it at once.
            bus.oDone     <= (state == DONE) && !startLoad;
            bus.oError    <= (state == ERROR) && !startLoad;
            bus.oCpuReset <= !((state == DONE) && !startLoad);

            // The address holds at the last index rather than stepping past the end.
            if (wordValid) begin
                wordsLeft <= wordsLeft - 16'd1;
                if (wordsLeft != 16'd1) begin
                    addrCnt <= addrCnt + 1'b1;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            if (byteAccept && (state != CHECK)) begin
                xorAcc <= xorAcc ^ bus.iByte;
            end
`endif

            case (state)
                IDLE, DONE, ERROR: begin
                    if (startLoad) begin
                        state     <= LEN_HI;
                        wordsLeft <= '0;
                        addrCnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xorAcc    <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (byteAccept) begin
                        lenHi <= bus.iByte;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (byteAccept) begin
                        if (lenTooLong) begin
                            state <= ERROR;
                        end else if (lenValue == 16'd0) begin
                            state <= finishState;
                        end else begin
                            state     <= DATA;
                            wordsLeft <= lenValue;
                            addrCnt   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (byteAccept) begin
                        if (badNibble) begin
                            state <= ERROR;
                        end else if (lastByteOfLoad) begin
                            state <= finishState;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (byteAccept) begin
                        state <= (bus.iByte == xorAcc) ? DONE : ERROR;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
